// File: rtl/lut_decoder_pkg.sv
// Shared definitions for the LUT decoder stimulus generator: signed-digit codes,
// default format count and FSM state codes.
package lut_decoder_pkg;

    localparam int unsigned NUM_FMT_DEF = 3;
    localparam int unsigned DIG_W       = 2;

    localparam logic [DIG_W-1:0] DIG_ZERO = 2'b00;
    localparam logic [DIG_W-1:0] DIG_POS  = 2'b01;
    localparam logic [DIG_W-1:0] DIG_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sweep order of a signed digit is 0, +1, -1; the unused code 2'b10 folds back to 0.
    function automatic logic [DIG_W-1:0] next_digit(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] nd;
        case (d)
            DIG_ZERO: nd = DIG_POS;
            DIG_POS:  nd = DIG_NEG;
            default:  nd = DIG_ZERO;
        endcase
        return nd;
    endfunction

endpackage

// File: rtl/lut_decoder_digit_cnt.sv
// Three-value signed-digit counter (0, +1, -1) with a carry-out on the -1 -> 0 wrap.
module lut_decoder_digit_cnt
    import lut_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             arst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [DIG_W-1:0] o_value,
    output logic             o_carry_c
);

    logic [DIG_W-1:0] r_value;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_value <= DIG_ZERO;
        end else if (i_clr) begin
            r_value <= DIG_ZERO;
        end else if (i_inc) begin
            r_value <= next_digit(r_value);
        end
    end

    assign o_value   = r_value;
    assign o_carry_c = i_inc && (r_value == DIG_NEG);

endmodule

// File: rtl/lut_decoder_stim_gen.sv
// Stimulus sweep generator: walks mode/format/n/d_x/d_y in nested order and
// issues one vector per enabled RUN cycle on registered outputs.
module lut_decoder_stim_gen
    import lut_decoder_pkg::*;
#(
    parameter int unsigned LOG2N   = 6,
    parameter int unsigned WC      = 16,
    parameter int unsigned NUM_FMT = NUM_FMT_DEF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic [LOG2N-1:0] cfg_n_max,
    output logic             tb_mode,
    output logic [1:0]       tb_format,
    output logic [LOG2N-1:0] tb_n,
    output logic [1:0]       tb_d_x_n,
    output logic [1:0]       tb_d_y_n,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [WC-1:0]    vec_cnt
);

    localparam logic [1:0] FMT_LAST = 2'(NUM_FMT - 1);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_clr;
    logic   w_issue;

    // Sweep position: the vector that will be issued next.
    logic             r_mode;
    logic [1:0]       r_fmt;
    logic [LOG2N-1:0] r_n;
    logic [LOG2N-1:0] r_n_max;
    logic [1:0]       w_dx;
    logic [1:0]       w_dy;
    logic             w_y_carry;
    logic             w_x_carry;
    logic             w_n_carry;
    logic             w_fmt_carry;
    logic             w_mode_carry;

    // Registered outputs and end-of-sweep flag.
    logic             r_last;
    logic             r_valid;
    logic             r_tb_mode;
    logic [1:0]       r_tb_format;
    logic [LOG2N-1:0] r_tb_n;
    logic [1:0]       r_tb_d_x_n;
    logic [1:0]       r_tb_d_y_n;
    logic [WC-1:0]    r_vec_cnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // srst outranks start/enable; start is only honoured outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_issue     = 1'b0;
        if (srst) begin
            w_state_nxt = ST_IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_clr       = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (enable) begin
                        w_issue = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    lut_decoder_digit_cnt u_dy (
        .clk       (clk),
        .arst      (arst),
        .i_clr     (w_clr),
        .i_inc     (w_issue),
        .o_value   (w_dy),
        .o_carry_c (w_y_carry)
    );

    lut_decoder_digit_cnt u_dx (
        .clk       (clk),
        .arst      (arst),
        .i_clr     (w_clr),
        .i_inc     (w_y_carry),
        .o_value   (w_dx),
        .o_carry_c (w_x_carry)
    );

    assign w_n_carry    = w_x_carry && (r_n == r_n_max);
    assign w_fmt_carry  = w_n_carry && (r_fmt == FMT_LAST);
    assign w_mode_carry = w_fmt_carry && r_mode;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_mode      <= 1'b0;
            r_fmt       <= 2'd0;
            r_n         <= '0;
            r_n_max     <= '0;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_tb_mode   <= 1'b0;
            r_tb_format <= 2'd0;
            r_tb_n      <= '0;
            r_tb_d_x_n  <= DIG_ZERO;
            r_tb_d_y_n  <= DIG_ZERO;
            r_vec_cnt   <= '0;
        end else if (w_clr) begin
            r_mode      <= 1'b0;
            r_fmt       <= 2'd0;
            r_n         <= '0;
            r_n_max     <= srst ? '0 : cfg_n_max;
            r_last      <= 1'b0;
            r_valid     <= 1'b0;
            r_tb_mode   <= 1'b0;
            r_tb_format <= 2'd0;
            r_tb_n      <= '0;
            r_tb_d_x_n  <= DIG_ZERO;
            r_tb_d_y_n  <= DIG_ZERO;
            r_vec_cnt   <= '0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_tb_mode   <= r_mode;
                r_tb_format <= r_fmt;
                r_tb_n      <= r_n;
                r_tb_d_x_n  <= w_dx;
                r_tb_d_y_n  <= w_dy;
                r_last      <= w_mode_carry;
                if (r_vec_cnt != '1) begin
                    r_vec_cnt <= r_vec_cnt + WC'(1);
                end
            end
            if (w_x_carry) begin
                r_n <= w_n_carry ? '0 : r_n + LOG2N'(1);
            end
            if (w_n_carry) begin
                r_fmt <= w_fmt_carry ? 2'd0 : r_fmt + 2'd1;
            end
            if (w_fmt_carry) begin
                r_mode <= ~r_mode;
            end
        end
    end

    assign tb_mode   = r_tb_mode;
    assign tb_format = r_tb_format;
    assign tb_n      = r_tb_n;
    assign tb_d_x_n  = r_tb_d_x_n;
    assign tb_d_y_n  = r_tb_d_y_n;
    assign valid     = r_valid;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign vec_cnt   = r_vec_cnt;

endmodule

// File: doc/lut_decoder_stim_gen.md
LUT_DECODER_STIM_GEN -- requirements
Module: lut_decoder_stim_gen

Interface
REQ-001 SHALL have parameter LOG2N, default 6, giving the width of the iteration index.
REQ-002 SHALL have parameter WC, default 16, giving the width of the vector counter.
REQ-003 SHALL have parameter NUM_FMT, default 3, giving the number of legal format codes (0..NUM_FMT-1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port srst, input, 1 bit: synchronous, active-high clear.
REQ-007 SHALL have port enable, input, 1 bit: advance permission.
REQ-008 SHALL have port start, input, 1 bit: begins a sweep.
REQ-009 SHALL have port cfg_n_max, input, LOG2N bits: last iteration index, sampled at start.
REQ-010 SHALL have outputs tb_mode (1 bit), tb_format (2 bits), tb_n (LOG2N bits), tb_d_x_n (2 bits) and tb_d_y_n (2 bits): the current stimulus vector.
REQ-011 SHALL have output valid, 1 bit: the stimulus vector is new this cycle.
REQ-012 SHALL have outputs busy (1 bit), done (1 bit) and vec_cnt (WC bits): the number of vectors issued.

Function
REQ-013 SHALL encode signed digits as 2'b00 = 0, 2'b01 = +1, 2'b11 = -1; 2'b10 SHALL never be driven.
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL move IDLE->RUN, or DONE->RUN, on start=1, latching cfg_n_max and clearing vec_cnt and done.
REQ-016 SHALL ignore start while in RUN.
REQ-017 SHALL sweep in RUN in nested order, innermost first:
- d_y: 0, +1, -1
- d_x: 0, +1, -1
- n: 0..n_max
- format: 0..NUM_FMT-1
- mode: 0, 1
REQ-018 SHALL, in RUN with enable=1, issue exactly one vector per cycle with valid=1 and increment vec_cnt by 1.
REQ-019 SHALL, in RUN with enable=0, hold all tb_* outputs and vec_cnt, with valid=0.
REQ-020 SHALL drive the first vector (all fields 0) in the first enabled RUN cycle, with valid=1 in that same cycle (latency 1 cycle from start).
REQ-021 SHALL, when each inner digit wraps from -1 to 0, carry into the next field; n SHALL wrap from n_max to 0.
REQ-022 SHALL, on the cycle the last vector is issued (mode=1, format=NUM_FMT-1, n=n_max, d_x=-1, d_y=-1), go to DONE on the next edge.
REQ-023 SHALL hold done=1 in DONE, sticky until the next start.
REQ-024 SHALL make the total vector count 2*NUM_FMT*(n_max+1)*9; vec_cnt SHALL saturate at 2**WC-1.
REQ-025 SHALL accept cfg_n_max=0 as legal (single n value).
REQ-026 SHALL drive busy=1 exactly in RUN, and valid=0 outside RUN.
REQ-027 SHALL give srst priority over start and enable when both are high in the same cycle.

Reset
REQ-028 SHALL, on arst=1, immediately (asynchronously) return to IDLE with all outputs 0.
REQ-029 SHALL, on srst=1 at a clock edge, return to IDLE with all outputs 0, including mid-sweep; the sweep SHALL NOT resume afterwards.
REQ-030 SHALL restart from the first vector on a start after reset.

Structure
REQ-031 SHALL place the digit encodings, NUM_FMT default and FSM state codes in a shared header for lut_decoder_pkg, which is also used by lut_decoder and lut_decoder_checker.
REQ-032 SHALL implement the 3-value digit counter (value, increment, carry-out) as sub-module lut_decoder_digit_cnt, instantiated twice.
REQ-033 SHALL be fully synthesizable, using no real types.

Verification
REQ-034 SHALL cover: LOG2N=2, cfg_n_max=0, start pulse, enable=1 -> 54 valid cycles, then done=1 and vec_cnt=54.
REQ-035 SHALL cover: cfg_n_max=3 -> 216 vectors, with the last vector mode=1, format=2, n=3, d_x=2'b11, d_y=2'b11, and no 2'b10 digit ever issued.
REQ-036 SHALL cover: enable toggled 1/0 every cycle -> identical vector sequence, valid=0 on stalled cycles, and completion after 108 cycles for cfg_n_max=0.
REQ-037 SHALL cover: srst at vector 20 -> IDLE, vec_cnt=0, valid=0; a new start then reissues vector 0.
REQ-038 SHALL cover: start asserted mid-RUN -> ignored, with the sequence and vec_cnt unaffected.
REQ-039 SHALL cover: arst asserted between clock edges -> outputs reach 0 before the next edge.
